// File: rtl/ram_burst_ctrl_if.sv
// Bundle of command, write-stream, read-stream and RAM-side signals for ram_burst_ctrl.
// The controller uses the slave modport; the environment (source, sink, RAM) uses master.
interface ram_burst_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len_m1;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] ram_data_in;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_mode;
    logic [DATA_W-1:0] ram_data_out;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len_m1,
        input  wr_valid, wr_data, rd_ready, ram_data_out,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
        output ram_data_in, ram_addr, ram_mode
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len_m1,
        output wr_valid, wr_data, rd_ready, ram_data_out,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
        input  ram_data_in, ram_addr, ram_mode
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a 64x8 single-port RAM (sync write, async read):
// one command per burst, valid/ready write stream in, registered valid/ready read stream out.
module ram_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    ram_burst_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] dcnt_q, dcnt_d;
    logic              iss_done_q, iss_done_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              wr_ready_q, wr_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;
    logic              deliver;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        iss_done_d = iss_done_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        load       = 1'b0;
        deliver    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d     = bus.cmd_addr;
                    cnt_d      = bus.cmd_len_m1;
                    dcnt_d     = bus.cmd_len_m1;
                    iss_done_d = 1'b0;
                    state_d    = bus.cmd_write ? WRITE : READ;
                end
            end

            WRITE: begin
                if (bus.wr_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - ADDR_W'(1);
                    end
                end
            end

            READ: begin
                // Issue side refills the output register whenever it is empty or draining.
                load    = (!rd_valid_q || bus.rd_ready) && !iss_done_q;
                deliver = rd_valid_q && bus.rd_ready;
                if (load) begin
                    rd_data_d  = bus.ram_data_out;
                    rd_valid_d = 1'b1;
                    addr_d     = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        iss_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ADDR_W'(1);
                    end
                end else if (deliver) begin
                    rd_valid_d = 1'b0;
                end
                if (deliver) begin
                    if (dcnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        dcnt_d = dcnt_q - ADDR_W'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WRITE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            iss_done_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            iss_done_q  <= iss_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Write strobe is gated by rst so the edge that aborts a burst cannot also write the RAM.
    assign bus.ram_mode    = wr_ready_q && bus.wr_valid && !rst;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_data_in = bus.wr_data;
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.wr_ready    = wr_ready_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed and randomized bench for ram_burst_ctrl with a 64x8 RAM model and an
// expected-memory reference updated burst by burst.
module tb_ram_burst_ctrl;

    logic clk;
    logic rst;
    logic clr;

    ram_burst_ctrl_if #(.DATA_W(8), .ADDR_W(6)) bus ();

    ram_burst_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM environment: synchronous write, asynchronous read
    logic [7:0] mem [64];
    int         wr_count;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 7 + 3);
            wr_count <= 0;
        end else if (bus.ram_mode) begin
            mem[bus.ram_addr] <= bus.ram_data_in;
            wr_count <= wr_count + 1;
        end
    end

    assign bus.ram_data_out = mem[bus.ram_addr];

    // Reference: what every RAM location should hold
    logic [7:0] exp_mem [64];
    logic [7:0] wbuf [64];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        checks++;
        errors++;
        $display("FAIL %s observed=timeout expected=completion", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] wrap(input logic [5:0] a, input int k);
        return a + 6'(k);
    endfunction

    task automatic drive_noise(input bit noisy);
        bus.cmd_valid  = noisy ? 1'($urandom_range(1)) : 1'b0;
        bus.cmd_write  = 1'($urandom_range(1));
        bus.cmd_addr   = 6'($urandom_range(63));
        bus.cmd_len_m1 = 6'($urandom_range(63));
    endtask

    task automatic send_cmd(input logic wr, input logic [5:0] a, input logic [5:0] l);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) fail_timeout("cmd_wait");
        bus.cmd_valid  = 1'b1;
        bus.cmd_write  = wr;
        bus.cmd_addr   = a;
        bus.cmd_len_m1 = l;
        tick();
        bus.cmd_valid = 1'b0;
        check("busy_after_cmd", 32'(bus.busy), 32'(1));
        check("cmd_ready_after_cmd", 32'(bus.cmd_ready), 32'(0));
    endtask

    task automatic check_done_then_idle(input string kind);
        check({kind, "_done_pulse"}, 32'(bus.done), 32'(1));
        check({kind, "_done_cmd_ready"}, 32'(bus.cmd_ready), 32'(0));
        check({kind, "_done_busy"}, 32'(bus.busy), 32'(1));
        tick();
        check({kind, "_idle_done"}, 32'(bus.done), 32'(0));
        check({kind, "_idle_cmd_ready"}, 32'(bus.cmd_ready), 32'(1));
        check({kind, "_idle_busy"}, 32'(bus.busy), 32'(0));
    endtask

    task automatic wr_burst(input logic [5:0] a, input logic [5:0] l, input int gap_pct, input bit noisy);
        int n    = int'(l) + 1;
        int sent = 0;
        int cyc  = 0;
        int w0   = wr_count;
        send_cmd(1'b1, a, l);
        while (sent < n && cyc < 2000) begin
            bus.wr_valid = ($urandom_range(99) >= 32'(gap_pct));
            bus.wr_data  = wbuf[sent];
            drive_noise(noisy);
            #1;
            check("wr_ready", 32'(bus.wr_ready), 32'(1));
            check("wr_mode", 32'(bus.ram_mode), 32'(bus.wr_valid));
            check("wr_addr", 32'(bus.ram_addr), 32'(wrap(a, sent)));
            check("wr_busy", 32'(bus.busy), 32'(1));
            check("wr_cmd_ready", 32'(bus.cmd_ready), 32'(0));
            @(posedge clk);
            #1;
            if (bus.wr_valid) begin
                exp_mem[wrap(a, sent)] = wbuf[sent];
                sent++;
            end
            cyc++;
        end
        bus.wr_valid  = 1'b0;
        bus.cmd_valid = 1'b0;
        if (sent < n) fail_timeout("wr_burst");
        if (gap_pct == 0) check("wr_latency", 32'(cyc), 32'(n));
        check("wr_count", 32'(wr_count - w0), 32'(n));
        check_done_then_idle("wr");
    endtask

    // mode 0: sink always ready; 1: ready from pat then 1; 2: random ready
    task automatic rd_burst(input logic [5:0] a, input logic [5:0] l, input int mode,
                            input logic [15:0] pat, input bit noisy);
        int         n       = int'(l) + 1;
        int         got     = 0;
        int         cyc     = 0;
        bit         stalled = 1'b0;
        bit         acc;
        logic [7:0] held    = '0;
        int         w0      = wr_count;
        send_cmd(1'b0, a, l);
        while (got < n && cyc < 2000) begin
            case (mode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = (cyc < 16) ? pat[cyc] : 1'b1;
                default: bus.rd_ready = 1'($urandom_range(1));
            endcase
            drive_noise(noisy);
            #1;
            check("rd_mode", 32'(bus.ram_mode), 32'(0));
            check("rd_wr_ready", 32'(bus.wr_ready), 32'(0));
            check("rd_busy", 32'(bus.busy), 32'(1));
            check("rd_cmd_ready", 32'(bus.cmd_ready), 32'(0));
            if (cyc == 0) check("rd_first_lat0", 32'(bus.rd_valid), 32'(0));
            if (cyc == 1) check("rd_first_lat1", 32'(bus.rd_valid), 32'(1));
            if (stalled) begin
                check("rd_hold_valid", 32'(bus.rd_valid), 32'(1));
                check("rd_hold_data", 32'(bus.rd_data), 32'(held));
            end
            if (bus.rd_valid) check("rd_data", 32'(bus.rd_data), 32'(exp_mem[wrap(a, got)]));
            stalled = bus.rd_valid && !bus.rd_ready;
            held    = bus.rd_data;
            acc     = bus.rd_valid && bus.rd_ready;
            @(posedge clk);
            #1;
            if (acc) got++;
            cyc++;
        end
        bus.rd_ready  = 1'b0;
        bus.cmd_valid = 1'b0;
        if (got < n) fail_timeout("rd_burst");
        if (mode == 0) check("rd_throughput", 32'(cyc), 32'(n + 1));
        check("rd_no_writes", 32'(wr_count - w0), 32'(0));
        check("rd_valid_after_last", 32'(bus.rd_valid), 32'(0));
        check_done_then_idle("rd");
    endtask

    initial begin
        int w0;
        rst            = 1'b1;
        clr            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len_m1 = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.rd_ready   = 1'b0;
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i * 7 + 3);
        tick();
        tick();
        clr = 1'b0;
        rst = 1'b0;

        // Reset state
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
        check("rst_wr_ready", 32'(bus.wr_ready), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
        check("rst_rd_data", 32'(bus.rd_data), 32'(0));
        check("rst_ram_mode", 32'(bus.ram_mode), 32'(0));
        check("rst_ram_addr", 32'(bus.ram_addr), 32'(0));

        // Single write then read back
        wbuf[0] = 8'hA5;
        wr_burst(6'd5, 6'd0, 0, 1'b0);
        check("single_mem5", 32'(mem[5]), 32'(8'hA5));
        rd_burst(6'd5, 6'd0, 0, 16'h0, 1'b0);

        // Wrap-around burst
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        wr_burst(6'd62, 6'd3, 0, 1'b0);
        check("wrap_mem62", 32'(mem[62]), 32'(8'h11));
        check("wrap_mem63", 32'(mem[63]), 32'(8'h22));
        check("wrap_mem0", 32'(mem[0]), 32'(8'h33));
        check("wrap_mem1", 32'(mem[1]), 32'(8'h44));
        rd_burst(6'd62, 6'd3, 0, 16'h0, 1'b0);

        // Read backpressure 1,0,0,1,1,0,1 and write stalls
        rd_burst(6'd62, 6'd3, 1, 16'b1011001, 1'b0);
        wbuf[0] = 8'h5C; wbuf[1] = 8'hC5; wbuf[2] = 8'h7E;
        wr_burst(6'd40, 6'd2, 50, 1'b0);
        rd_burst(6'd40, 6'd2, 2, 16'h0, 1'b0);

        // Full 64-word burst with command noise
        for (int i = 0; i < 64; i++) wbuf[i] = 8'(i);
        wr_burst(6'd0, 6'd63, 20, 1'b1);
        for (int i = 0; i < 64; i++) check("full_mem", 32'(mem[i]), 32'(i));
        rd_burst(6'd0, 6'd63, 0, 16'h0, 1'b1);

        // Reset in the middle of a write burst
        for (int i = 0; i < 8; i++) wbuf[i] = 8'(8'h90 + i);
        send_cmd(1'b1, 6'd20, 6'd7);
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wbuf[i];
            tick();
            exp_mem[wrap(6'd20, i)] = wbuf[i];
        end
        bus.wr_data = 8'hEE;
        w0  = wr_count;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("abort_no_write", 32'(wr_count - w0), 32'(0));
        check("abort_cmd_ready", 32'(bus.cmd_ready), 32'(1));
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_wr_ready", 32'(bus.wr_ready), 32'(0));
        check("abort_ram_mode", 32'(bus.ram_mode), 32'(0));
        check("abort_rd_valid", 32'(bus.rd_valid), 32'(0));
        check("abort_done", 32'(bus.done), 32'(0));
        tick();
        bus.wr_valid = 1'b0;
        check("abort_idle_no_write", 32'(wr_count - w0), 32'(0));
        check("abort_mem23", 32'(mem[23]), 32'(exp_mem[23]));
        rd_burst(6'd20, 6'd3, 0, 16'h0, 1'b0);

        // Randomized bursts against the reference memory
        for (int k = 0; k < 12; k++) begin
            logic [5:0] a = 6'($urandom_range(63));
            logic [5:0] l = 6'($urandom_range(15));
            for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom_range(255));
            wr_burst(a, l, int'($urandom_range(60)), 1'($urandom_range(1)));
            a = 6'($urandom_range(63));
            l = 6'($urandom_range(20));
            rd_burst(a, l, int'($urandom_range(2)), 16'($urandom_range(65535)), 1'($urandom_range(1)));
        end
        for (int i = 0; i < 64; i++) check("final_mem", 32'(mem[i]), 32'(exp_mem[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
